// File: rtl/cdc_fifo_pkg.sv
// rtl/cdc_fifo_pkg.sv - shared constants and Gray-code helpers for the dual-clock FIFO
package cdc_fifo_pkg;

    localparam int DEFAULT_ADDR_WIDTH  = 4;
    localparam int DEFAULT_SYNC_STAGES = 2;

    // Helpers work on a fixed wide vector; callers zero-extend and keep the low bits.
    localparam int GRAY_WIDTH = 32;

    function automatic logic [GRAY_WIDTH-1:0] bin2gray(input logic [GRAY_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_WIDTH-1:0] gray2bin(input logic [GRAY_WIDTH-1:0] gray);
        logic [GRAY_WIDTH-1:0] bin;
        bin[GRAY_WIDTH-1] = gray[GRAY_WIDTH-1];
        for (int i = GRAY_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/cdc_sync_bus.sv
// rtl/cdc_sync_bus.sv - multi-flop synchroniser chain for a Gray-coded bus
module cdc_sync_bus #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_chain [SYNC_STAGES];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_chain[i] <= '0;
            end
        end else begin
            r_chain[0] <= i_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_data = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_fifo_write_ctrl.sv
// rtl/cdc_fifo_write_ctrl.sv - write-domain pointer, level and flag logic for the dual-clock FIFO
module cdc_fifo_write_ctrl
    import cdc_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH         = DEFAULT_ADDR_WIDTH,
    parameter int SYNC_STAGES        = DEFAULT_SYNC_STAGES,
    parameter int ALMOST_FULL_THRESH = 2**ADDR_WIDTH - 2
) (
    input  logic                  write_clk,
    input  logic                  write_rst,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH:0]   read_ptr_gray_async,
    input  logic                  clear_overflow,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   write_level,
    output logic                  overflow,
    output logic [ADDR_WIDTH-1:0] write_addr_out,
    output logic                  write_enable_out,
    output logic [ADDR_WIDTH:0]   write_addr_gray
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [PTR_W-1:0] DEPTH_P  = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] THRESH_P = PTR_W'(ALMOST_FULL_THRESH);

    if (ADDR_WIDTH < 1 || PTR_W >= GRAY_WIDTH) begin : g_bad_addr_width
        $error("cdc_fifo_write_ctrl: ADDR_WIDTH out of range");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("cdc_fifo_write_ctrl: SYNC_STAGES must be at least 2");
    end
    if (ALMOST_FULL_THRESH < 1 || ALMOST_FULL_THRESH > DEPTH) begin : g_bad_thresh
        $error("cdc_fifo_write_ctrl: ALMOST_FULL_THRESH must lie in 1..DEPTH");
    end

    logic [PTR_W-1:0]      r_wptr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_wen_out;
    logic [PTR_W-1:0]      r_gray;
    logic [PTR_W-1:0]      r_level;
    logic                  r_full;
    logic                  r_almost_full;
    logic                  r_overflow;

    logic                  w_accept;
    logic [PTR_W-1:0]      w_wptr_next;
    logic [PTR_W-1:0]      w_rptr_gray_s;
    logic [PTR_W-1:0]      w_rptr_bin;
    logic [PTR_W-1:0]      w_level_next;
    logic [GRAY_WIDTH-1:0] w_gray_next_wide;
    logic [GRAY_WIDTH-1:0] w_rptr_bin_wide;
    logic                  w_unused_hi;

    cdc_sync_bus #(
        .WIDTH       (PTR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .i_clk  (write_clk),
        .i_rst  (write_rst),
        .i_data (read_ptr_gray_async),
        .o_data (w_rptr_gray_s)
    );

    assign w_accept         = write_enable & ~r_full;
    assign w_wptr_next      = r_wptr + PTR_W'(w_accept);
    assign w_gray_next_wide = bin2gray(GRAY_WIDTH'(w_wptr_next));
    assign w_rptr_bin_wide  = gray2bin(GRAY_WIDTH'(w_rptr_gray_s));
    assign w_rptr_bin       = w_rptr_bin_wide[PTR_W-1:0];
    // Stale read pointer makes this an over-estimate, which is the safe direction.
    assign w_level_next     = w_wptr_next - w_rptr_bin;
    assign w_unused_hi      = ^{w_gray_next_wide[GRAY_WIDTH-1:PTR_W], w_rptr_bin_wide[GRAY_WIDTH-1:PTR_W]};

    always_ff @(posedge write_clk or posedge write_rst) begin
        if (write_rst) begin
            r_wptr        <= '0;
            r_addr        <= '0;
            r_wen_out     <= 1'b0;
            r_gray        <= '0;
            r_level       <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_wptr        <= w_wptr_next;
            r_wen_out     <= w_accept;
            if (w_accept) begin
                r_addr    <= r_wptr[ADDR_WIDTH-1:0];
            end
            r_gray        <= w_gray_next_wide[PTR_W-1:0];
            r_level       <= w_level_next;
            r_full        <= (w_level_next == DEPTH_P);
            r_almost_full <= (w_level_next >= THRESH_P);
            if (write_enable && r_full) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign full             = r_full;
    assign almost_full      = r_almost_full;
    assign write_level      = r_level;
    assign overflow         = r_overflow;
    assign write_addr_out   = r_addr;
    assign write_enable_out = r_wen_out;
    assign write_addr_gray  = r_gray;

endmodule

// File: tb/tb_cdc_fifo_write_ctrl.sv
// tb/tb_cdc_fifo_write_ctrl.sv - self-checking bench for cdc_fifo_write_ctrl
module tb_cdc_fifo_write_ctrl;

    localparam int AW    = 3;
    localparam int PW    = AW + 1;
    localparam int SS    = 2;
    localparam int AFT   = 6;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          we  = 1'b0;
    logic          clr = 1'b0;
    logic [PW-1:0] rp_g = '0;

    logic          full, almost_full, overflow, wen_out;
    logic [PW-1:0] level, gray;
    logic [AW-1:0] addr;

    cdc_fifo_write_ctrl #(
        .ADDR_WIDTH         (AW),
        .SYNC_STAGES        (SS),
        .ALMOST_FULL_THRESH (AFT)
    ) dut (
        .write_clk           (clk),
        .write_rst           (rst),
        .write_enable        (we),
        .read_ptr_gray_async (rp_g),
        .clear_overflow      (clr),
        .full                (full),
        .almost_full         (almost_full),
        .write_level         (level),
        .overflow            (overflow),
        .write_addr_out      (addr),
        .write_enable_out    (wen_out),
        .write_addr_gray     (gray)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int to_gray(input int v);
        return (v ^ (v >> 1)) & 15;
    endfunction

    function automatic int from_gray(input int g);
        for (int v = 0; v < 16; v++) begin
            if (to_gray(v) == g) return v;
        end
        return -1;
    endfunction

    // Model: count of accepted writes and the read pointer as seen SS edges late.
    int m_wcount;
    int m_hist[$];
    int m_rb;
    int m_level, m_addr, m_gray;
    bit m_full, m_af, m_ovf, m_wen, m_acc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wcount = 0;
            m_hist   = {};
            for (int i = 0; i < SS; i++) m_hist.push_back(0);
            m_level = 0; m_addr = 0; m_gray = 0;
            m_full = 0; m_af = 0; m_ovf = 0; m_wen = 0;
        end else begin
            m_acc = we && !m_full;
            if (we && m_full) m_ovf = 1;
            else if (clr) m_ovf = 0;
            m_rb = from_gray(m_hist[0]);
            void'(m_hist.pop_front());
            m_hist.push_back(int'(rp_g));
            if (m_acc) begin
                m_addr = m_wcount % DEPTH;
                m_wcount++;
            end
            m_wen   = m_acc;
            m_level = (((m_wcount - m_rb) % 16) + 16) % 16;
            m_full  = (m_level == DEPTH);
            m_af    = (m_level >= AFT);
            m_gray  = to_gray(m_wcount % 16);
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("cmp_full",  full,        m_full);
            check("cmp_af",    almost_full, m_af);
            check("cmp_level", level,       m_level);
            check("cmp_ovf",   overflow,    m_ovf);
            check("cmp_wen",   wen_out,     m_wen);
            check("cmp_gray",  gray,        m_gray);
            if (m_wen) check("cmp_addr", addr, m_addr);
        end
    end

    task automatic cyc(input bit w, input bit c);
        we  = w;
        clr = c;
        @(negedge clk);
    endtask

    int wc;
    logic [PW-1:0] prev_gray;
    bit seen_gray_wrap, seen_addr_wrap;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_full",  full, 0);
        check("rst_level", level, 0);
        check("rst_gray",  gray, 0);
        check("rst_wen",   wen_out, 0);
        check("rst_ovf",   overflow, 0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // 1: eight back-to-back writes
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0);
            check("t1_wen",  wen_out, 1);
            check("t1_addr", addr, i);
            check("t1_af",   almost_full, (i + 1 >= 6) ? 1 : 0);
            check("t1_full", full, (i == 7) ? 1 : 0);
        end
        check("t1_level", level, 8);
        check("t1_gray",  gray, 4'b1100);
        check("t1_model_level", m_level, 8);
        wc = 8;

        // 2: writes while full set the sticky overflow
        cyc(1, 0);
        check("t2_wen",  wen_out, 0);
        check("t2_ovf",  overflow, 1);
        check("t2_gray", gray, 4'b1100);
        cyc(1, 0);
        cyc(1, 0);
        check("t2_wen3", wen_out, 0);
        cyc(1, 1);
        check("t2_ovf_set_wins", overflow, 1);
        cyc(0, 1);
        check("t2_ovf_clr", overflow, 0);

        // 3: read pointer jumps to 3; release after three edges
        rp_g = 4'b0010;
        cyc(0, 0);
        check("t3_full_e1", full, 1);
        cyc(0, 0);
        check("t3_full_e2", full, 1);
        cyc(0, 0);
        check("t3_full_e3",  full, 0);
        check("t3_level_e3", level, 5);
        check("t3_af_e3",    almost_full, 0);
        cyc(1, 0);
        check("t3_addr", addr, 0);
        check("t3_wen",  wen_out, 1);
        wc = 9;

        // 4: wrap-around with a trailing read pointer
        rp_g = PW'(to_gray(wc % 16));
        cyc(0, 0); cyc(0, 0); cyc(0, 0);
        check("t4_drained", level, 0);
        prev_gray = gray;
        seen_gray_wrap = 0;
        seen_addr_wrap = 0;
        for (int i = 0; i < 20; i++) begin
            rp_g = PW'(to_gray(wc % 16));
            cyc(1, 0);
            check("t4_wen",    wen_out, 1);
            check("t4_addr",   addr, wc % 8);
            check("t4_onebit", $countones(gray ^ prev_gray), 1);
            check("t4_lvl_le4", (level <= 4) ? 1 : 0, 1);
            if (prev_gray == 4'b1000 && gray == 4'b0000) seen_gray_wrap = 1;
            if (wc % 8 == 0) seen_addr_wrap = 1;
            prev_gray = gray;
            wc++;
        end
        check("t4_gray_wrap", seen_gray_wrap, 1);
        check("t4_addr_wrap", seen_addr_wrap, 1);

        // 5: write and read advance on the same edge at level 7
        cyc(0, 0); cyc(0, 0);
        check("t5_base_level", level, 1);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0);
            wc++;
        end
        check("t5_level7", level, 7);
        rp_g = PW'(to_gray(29 % 16));
        cyc(0, 0);
        cyc(0, 0);
        check("t5_pre_level", level, 7);
        cyc(1, 0);
        wc++;
        check("t5_wen",   wen_out, 1);
        check("t5_level", level, 7);
        check("t5_full",  full, 0);
        check("t5_af",    almost_full, 1);

        // 6: asynchronous reset mid-burst
        we = 1'b1;
        @(posedge clk);
        #1;
        check("t6_pre_wen", wen_out, 1);
        #1;
        rst  = 1'b1;
        we   = 1'b0;
        rp_g = '0;
        #1;
        check("t6_rst_full",  full, 0);
        check("t6_rst_af",    almost_full, 0);
        check("t6_rst_level", level, 0);
        check("t6_rst_wen",   wen_out, 0);
        check("t6_rst_addr",  addr, 0);
        check("t6_rst_gray",  gray, 0);
        check("t6_rst_ovf",   overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0);
        check("t6_idle_wen1", wen_out, 0);
        cyc(0, 0);
        check("t6_idle_wen2", wen_out, 0);
        cyc(1, 0);
        check("t6_new_wen",   wen_out, 1);
        check("t6_new_addr",  addr, 0);
        check("t6_new_level", level, 1);
        cyc(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
